ram_block: RTL and testbench

Single-port, word-addressed synchronous RAM with a bidirectional (tri-state) data bus, used as the main memory array behind the memory controller. The controller presents a word address and one-cycle read or write strobes. The block writes the shared bus into the array, or drives the addressed word back onto the same bus. It has no handshake of its own: every access completes with fixed latency.

---
 rtl/ram_block_pkg.sv | 12 +
 rtl/ram_block.sv | 55 +++++
 tb/tb_ram_block.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ram_block_pkg.sv
// Shared sizing constants for the memory subsystem.
//   DWIDTH    : data word width in bits
//   AWIDTH    : word-address width (array depth = 2**AWIDTH words)
//   CPUAWIDTH : CPU byte-address width seen by the controller in front of
//               the RAM (word address plus the two byte-offset bits)
package InstructionStruct;

    localparam int DWIDTH    = 32;
    localparam int AWIDTH    = 10;
    localparam int CPUAWIDTH = AWIDTH + 2;

endpackage : InstructionStruct

// File: rtl/ram_block.sv
// Single-port, word-addressed synchronous RAM with a shared tri-state data bus.
//
// Ports:
//   clk   in     1       rising-edge clock for all state
//   reset in     1       synchronous active-high reset (clears the read path only)
//   data  inout  DWIDTH  sampled on writes, driven for one cycle after a read
//   addr  in     AWIDTH  word address
//   rdEn  in     1       read strobe
//   wrEn  in     1       write strobe; wins over rdEn when both are high
//
// Parameters:
//   DWIDTH, AWIDTH  default from InstructionStruct
//   INIT_FILE       image name; the array powers up zeroed
module ram_block #(
    parameter int    DWIDTH    = InstructionStruct::DWIDTH,
    parameter int    AWIDTH    = InstructionStruct::AWIDTH,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    inout  logic [DWIDTH-1:0] data,
    input  logic [AWIDTH-1:0] addr,
    input  logic              rdEn,
    input  logic              wrEn
);

    localparam int DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH] = '{default: '0};

    // Power-up values hold until the first reset: bus released, output zero.
    logic [DWIDTH-1:0] out_reg  = '0;
    logic              drive_en = 1'b0;

    // Reset only touches the read path; the array keeps its contents.
    // A write suppresses a simultaneous read so the block never drives the
    // bus while the controller is driving write data onto it.
    always_ff @(posedge clk) begin
        if (reset) begin
            drive_en <= 1'b0;
            out_reg  <= '0;
        end else if (wrEn) begin
            mem[addr] <= data;
            drive_en  <= 1'b0;
        end else if (rdEn) begin
            out_reg  <= mem[addr];
            drive_en <= 1'b1;
        end else begin
            drive_en <= 1'b0;
        end
    end

    assign data = drive_en ? out_reg : 'z;

endmodule : ram_block

// File: tb/tb_ram_block.sv
// Directed self-checking bench for ram_block.
// Bus release is checked through the read-path enable and by having the
// bench drive a probe value: if the RAM were also driving, the resolved bus
// would differ from the probe.
module tb_ram_block;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] addr;
    logic          rdEn;
    logic          wrEn;
    logic [DW-1:0] tb_data;
    logic          tb_drive;
    wire  [DW-1:0] data;

    int n_checks = 0;
    int n_fail   = 0;

    assign data = tb_drive ? tb_data : 'z;

    ram_block #(.DWIDTH(DW), .AWIDTH(AW), .INIT_FILE("")) dut (
        .clk   (clk),
        .reset (reset),
        .data  (data),
        .addr  (addr),
        .rdEn  (rdEn),
        .wrEn  (wrEn)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // RAM must not be driving: enable low and a bench-driven zero reads back clean.
    task automatic check_released(input string tag);
        check({tag, "_en"}, {31'd0, dut.drive_en}, 32'd0);
        tb_data  = '0;
        tb_drive = 1'b1;
        #1;
        check({tag, "_bus"}, data, 32'd0);
        tb_drive = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr     = a;
        tb_data  = d;
        tb_drive = 1'b1;
        wrEn     = 1'b1;
        rdEn     = 1'b0;
        tick();
        wrEn     = 1'b0;
        tb_drive = 1'b0;
    endtask

    logic [DW-1:0] b2b_exp [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    initial begin
        reset    = 1'b1;
        addr     = '0;
        rdEn     = 1'b0;
        wrEn     = 1'b0;
        tb_data  = '0;
        tb_drive = 1'b0;

        #1;
        check("pwrup_out", dut.out_reg, 32'd0);
        check("pwrup_en", {31'd0, dut.drive_en}, 32'd0);

        // Reset for two edges, then idle.
        tick();
        tick();
        check_released("rst");
        reset = 1'b0;
        tick();
        check_released("idle");

        // Write then single read of address 5.
        do_write(10'd5, 32'hDEADBEEF);
        check_released("after_wr");
        addr = 10'd5;
        rdEn = 1'b1;
        tick();
        check("rd5", data, 32'hDEADBEEF);
        rdEn = 1'b0;
        tick();
        check_released("rd5_rel");
        check("rd5_hold", dut.out_reg, 32'hDEADBEEF);

        // Back-to-back reads with no gap.
        for (int i = 0; i < 4; i++) do_write(AW'(i), b2b_exp[i]);
        rdEn = 1'b1;
        addr = 10'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("b2b%0d", i), data, b2b_exp[i]);
            check($sformatf("b2b%0d_en", i), {31'd0, dut.drive_en}, 32'd1);
            addr = AW'(i + 1);
        end
        rdEn = 1'b0;
        tick();
        check_released("b2b_rel");

        // Reload out_reg with a value that would corrupt the bus if driven.
        addr = 10'd5;
        rdEn = 1'b1;
        tick();
        rdEn = 1'b0;
        tick();

        // Simultaneous strobes: write wins, no drive, out_reg unchanged.
        addr     = 10'd7;
        tb_data  = 32'h0000CAFE;
        tb_drive = 1'b1;
        rdEn     = 1'b1;
        wrEn     = 1'b1;
        tick();
        check("both_bus", data, 32'h0000CAFE);
        check("both_en", {31'd0, dut.drive_en}, 32'd0);
        check("both_out", dut.out_reg, 32'hDEADBEEF);
        wrEn     = 1'b0;
        tb_drive = 1'b0;
        tick();
        check("rd7", data, 32'h0000CAFE);

        // Reset on the same edge as a read, while the bus is being driven.
        addr  = 10'd5;
        reset = 1'b1;
        tick();
        check("rst_rd_out", dut.out_reg, 32'd0);
        check_released("rst_rd");
        reset = 1'b0;
        tick();
        check("rd5_post_rst", data, 32'hDEADBEEF);
        rdEn = 1'b0;
        tick();

        // Boundary addresses must not alias.
        do_write(10'h3FF, 32'hA5A5A5A5);
        do_write(10'h000, 32'h5A5A5A5A);
        addr = 10'h3FF;
        rdEn = 1'b1;
        tick();
        check("rd_top", data, 32'hA5A5A5A5);
        addr = 10'h000;
        tick();
        check("rd_bot", data, 32'h5A5A5A5A);
        addr = 10'd1;
        tick();
        check("rd1", data, 32'h22);
        rdEn = 1'b0;
        tick();
        check_released("end_rel");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ram_block
